// File: rtl/zylo_note_feeder.sv
// zylo_note_feeder: owns 64 falling-note slots and pushes them to the vga_zylo
// display once per frame over Avalon-MM. Frame cost: 64 + (active notes) + 1
// cycles with zero wait; writes stall while avm_waitrequest is high.
// Spawns are accepted only while idle and a slot is free.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   frame_tick          one-cycle pulse at start of vertical blank
//   spawn_valid/ready   new-note handshake; spawn_x, spawn_id carry the note
//   score, combo        sampled when the frame's final score write is loaded
//   avm_*               Avalon-MM master write port to the display
//   busy, overrun       frame in progress / sticky missed-tick flag
module zylo_note_feeder #(
  parameter int unsigned SPEED      = 4,
  parameter int unsigned Y_LIMIT    = 480,
  parameter logic [15:0] ADDR_NOTE  = 16'h6,
  parameter logic [15:0] ADDR_SCORE = 16'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        spawn_valid,
  output logic        spawn_ready,
  input  logic [9:0]  spawn_x,
  input  logic [5:0]  spawn_id,
  input  logic [15:0] score,
  input  logic [15:0] combo,
  output logic [15:0] avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_chipselect,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, EVAL, WRITE, SCORE} state_t;

  state_t      state, next_state;
  logic [63:0] slot_act;
  logic [9:0]  slot_x  [64];
  logic [9:0]  slot_y  [64];
  logic [5:0]  slot_id [64];
  logic [5:0]  idx;
  logic        pending;

  logic [5:0]  free_idx;
  logic        any_free;
  logic [10:0] sum;
  logic        fits;
  logic        last;
  logic        start;
  logic        wr_done;
  logic        spawn_xfer;

  // Lowest-index free slot: scanning downward lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (!slot_act[i]) free_idx = 6'(i);
    end
  end

  assign any_free   = ~&slot_act;
  assign sum        = {1'b0, slot_y[idx]} + 11'(SPEED);
  assign fits       = sum < 11'(Y_LIMIT);
  assign last       = (idx == 6'd63);
  assign start      = frame_tick || pending;
  assign wr_done    = !avm_waitrequest;
  assign spawn_xfer = spawn_valid && spawn_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = EVAL;
      EVAL: begin
        if (slot_act[idx]) next_state = WRITE;
        else if (last)     next_state = SCORE;
      end
      WRITE: if (wr_done) next_state = last ? SCORE : EVAL;
      SCORE: if (wr_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: decoded from the registered state so reset drops the
  // write strobe immediately.
  always_comb begin
    avm_write   = 1'b0;
    busy        = 1'b1;
    spawn_ready = 1'b0;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        spawn_ready = any_free;
      end
      WRITE, SCORE: avm_write = 1'b1;
      default: ;
    endcase
  end

  assign avm_chipselect = avm_write;

  // Control and bus registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_act      <= '0;
      idx           <= '0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      // A tick during a pass is remembered once; further ticks are absorbed.
      if (frame_tick && state != IDLE) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            pending <= 1'b0;
          end
          // id 0 is consumed by the handshake but never occupies a slot.
          if (spawn_xfer && spawn_id != 6'd0) slot_act[free_idx] <= 1'b1;
        end
        EVAL: begin
          if (slot_act[idx]) begin
            avm_address <= ADDR_NOTE;
            if (fits) begin
              avm_writedata <= {idx, slot_id[idx], sum[9:0], slot_x[idx]};
            end else begin
              // Retire packet blanks the display entry for this slot.
              slot_act[idx] <= 1'b0;
              avm_writedata <= {idx, 6'd0, 10'd0, slot_x[idx]};
            end
          end else if (!last) begin
            idx <= idx + 6'd1;
          end else begin
            avm_address   <= ADDR_SCORE;
            avm_writedata <= {combo, score};
          end
        end
        WRITE: begin
          if (wr_done) begin
            if (!last) begin
              idx <= idx + 6'd1;
            end else begin
              avm_address   <= ADDR_SCORE;
              avm_writedata <= {combo, score};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot payload; meaningful only while the matching active bit is set,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (spawn_xfer && spawn_id != 6'd0) begin
      slot_x[free_idx]  <= spawn_x;
      slot_y[free_idx]  <= '0;
      slot_id[free_idx] <= spawn_id;
    end
    if (state == EVAL && slot_act[idx] && fits) slot_y[idx] <= sum[9:0];
  end

endmodule
